// File: rtl/rand_range.sv
// Uniform random integer in [0, N-1] by masked rejection sampling over a free-running
// random word, with a bounded number of draws and a modular fallback on the last try.
module rand_range #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_TRIES = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      random,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_bound,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_value,
    output logic             resp_err,
    output logic             resp_fallback,
    output logic [15:0]      reject_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        DRAW,
        HOLD
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] bound;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] mask_next;
    logic [WIDTH-1:0] cand;
    logic [3:0]       tries;
    logic             last_try;
    logic             unused_random;

    // Smear N-1 rightwards so every bit below its MSB is set: smallest 2^k-1 >= N-1.
    always_comb begin
        mask_next = req_bound - WIDTH'(1);
        for (int unsigned i = 0; i < $clog2(WIDTH); i++) begin
            mask_next = mask_next | (mask_next >> (1 << i));
        end
        if (req_bound <= WIDTH'(1)) begin
            mask_next = '0;
        end
    end

    assign cand          = random[WIDTH-1:0] & mask;
    assign last_try      = (tries == 4'(MAX_TRIES - 1));
    assign unused_random = ^random;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bound         <= '0;
            mask          <= '0;
            tries         <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_value    <= '0;
            resp_err      <= 1'b0;
            resp_fallback <= 1'b0;
            reject_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        bound         <= req_bound;
                        mask          <= mask_next;
                        tries         <= '0;
                        req_ready     <= 1'b0;
                        resp_fallback <= 1'b0;
                        if (req_bound == '0) begin
                            resp_value <= '0;
                            resp_err   <= 1'b1;
                            resp_valid <= 1'b1;
                            state      <= HOLD;
                        end else begin
                            resp_err <= 1'b0;
                            state    <= DRAW;
                        end
                    end
                end
                DRAW: begin
                    if (cand < bound) begin
                        resp_value    <= cand;
                        resp_fallback <= 1'b0;
                        resp_valid    <= 1'b1;
                        state         <= HOLD;
                    end else begin
                        if (reject_cnt != '1) begin
                            reject_cnt <= reject_cnt + 16'd1;
                        end
                        // cand <= 2N-2 here, so cand - N always lands inside [0, N-1].
                        if (last_try) begin
                            resp_value    <= cand - bound;
                            resp_fallback <= 1'b1;
                            resp_valid    <= 1'b1;
                            state         <= HOLD;
                        end else begin
                            tries <= tries + 4'd1;
                        end
                    end
                end
                HOLD: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
